// File: rtl/uart_mem_loader_if.sv
// uart_mem_loader_if: receive-side word strobe, clear, memory write port and
// load status for the UART memory loader. The loader takes the slave view.
interface uart_mem_loader_if #(
  parameter int ADDR_W = 14
);
  logic [31:0]       word_in;
  logic              word_valid;
  logic              clear;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              load_done;
  logic [1:0]        err_code;
  logic [10:0]       words_loaded;

  modport master (
    output word_in, word_valid, clear,
    input  mem_addr, mem_wdata, mem_we, busy, load_done, err_code, words_loaded
  );

  modport slave (
    input  word_in, word_valid, clear,
    output mem_addr, mem_wdata, mem_we, busy, load_done, err_code, words_loaded
  );
endinterface

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: parses a header word from the UART word receiver, writes
// N payload words to consecutive addresses from BASE_ADDR, then reports done
// or an error code. Holds the core off until load_done.
// Optional feature macro: CHECKSUM_EN -- when defined, a trailing 32-bit
// modular-sum word must follow the payload; a mismatch gives err_code=3.
// TIMEOUT_CYCLES must be at least 2.
module uart_mem_loader #(
  parameter int              ADDR_W         = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 14'h1,
  parameter int              MAX_WORDS      = 2047,
  parameter logic [15:0]     MAGIC          = 16'hA55A,
  parameter int              TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  uart_mem_loader_if.slave bus
);

  localparam int          TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [10:0] MAXW    = 11'(MAX_WORDS);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_HDR  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
`ifdef CHECKSUM_EN
  localparam logic [1:0] ERR_SUM  = 2'd3;
`endif

  typedef enum logic [2:0] {
    S_WAIT_HDR,
    S_LOAD,
`ifdef CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [10:0]       n_q, idx_q, wl_q;
  logic [TW-1:0]     tmr_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        err_q;

  logic              accept, do_write, err_set, err_clr;
  logic [1:0]        err_val;
  logic              hdr_ok, last_word, active, tmo;

`ifdef CHECKSUM_EN
  logic [31:0]       sum_q;
`endif

  assign hdr_ok    = (bus.word_in[31:16] == MAGIC) && (bus.word_in[10:0] != 11'd0) &&
                     (bus.word_in[10:0] <= MAXW);
  assign last_word = (idx_q + 11'd1) == n_q;
`ifdef CHECKSUM_EN
  assign active    = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
  assign active    = (state_q == S_LOAD);
`endif
  // A word arriving on the final timer cycle keeps the load alive.
  assign tmo       = (tmr_q == TMR_MAX) && !bus.word_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_WAIT_HDR;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    do_write = 1'b0;
    err_set  = 1'b0;
    err_val  = ERR_NONE;
    err_clr  = 1'b0;
    case (state_q)
      S_WAIT_HDR: begin
        if (bus.word_valid) begin
          if (hdr_ok) begin
            accept  = 1'b1;
            state_d = S_LOAD;
          end else begin
            err_set = 1'b1;
            err_val = ERR_HDR;
            state_d = S_ERROR;
          end
        end
      end
      S_LOAD: begin
        if (bus.word_valid) begin
          do_write = 1'b1;
`ifdef CHECKSUM_EN
          if (last_word) state_d = S_CHECK;
`else
          if (last_word) state_d = S_DONE;
`endif
        end else if (tmo) begin
          err_set = 1'b1;
          err_val = ERR_TMO;
          state_d = S_ERROR;
        end
      end
`ifdef CHECKSUM_EN
      S_CHECK: begin
        // The checksum word is compared only, never written.
        if (bus.word_valid) begin
          if (bus.word_in == sum_q) begin
            state_d = S_DONE;
          end else begin
            err_set = 1'b1;
            err_val = ERR_SUM;
            state_d = S_ERROR;
          end
        end else if (tmo) begin
          err_set = 1'b1;
          err_val = ERR_TMO;
          state_d = S_ERROR;
        end
      end
`endif
      S_DONE, S_ERROR: begin
        // clear beats a simultaneous word; the word is dropped.
        if (bus.clear) begin
          err_clr = 1'b1;
          state_d = S_WAIT_HDR;
        end
      end
      default: state_d = S_WAIT_HDR;
    endcase
  end

  // Write port, counters, timer and error code.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wl_q    <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      we_q <= do_write;
      if (accept) begin
        n_q   <= bus.word_in[10:0];
        idx_q <= '0;
        wl_q  <= '0;
        tmr_q <= '0;
      end
      if (do_write) begin
        addr_q  <= BASE_ADDR + ADDR_W'(idx_q);
        wdata_q <= bus.word_in;
        idx_q   <= idx_q + 11'd1;
        wl_q    <= wl_q + 11'd1;
      end
      if (active) tmr_q <= bus.word_valid ? '0 : tmr_q + 1'b1;
      if (err_set)      err_q <= err_val;
      else if (err_clr) err_q <= ERR_NONE;
    end
  end

`ifdef CHECKSUM_EN
  // Running modular sum of the payload words.
  always_ff @(posedge clk) begin
    if (rst)           sum_q <= '0;
    else if (accept)   sum_q <= '0;
    else if (do_write) sum_q <= sum_q + bus.word_in;
  end
`endif

  assign bus.mem_we       = we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.words_loaded = wl_q;
  assign bus.err_code     = err_q;
  assign bus.busy         = active;
  assign bus.load_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: directed plus randomized load sequences checked every
// cycle against a behavioural model of the loader.
module tb_uart_mem_loader;
  localparam int          T    = 16;
  localparam logic [13:0] BASE = 14'h1;
`ifdef CHECKSUM_EN
  localparam bit HAS_CK = 1'b1;
`else
  localparam bit HAS_CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_mem_loader_if #(.ADDR_W(14)) bus();

  uart_mem_loader #(
    .ADDR_W(14), .BASE_ADDR(BASE), .MAX_WORDS(2047),
    .MAGIC(16'hA55A), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: load phases, words still expected, running sum.
  typedef enum int {M_IDLE, M_LOAD, M_CSUM, M_DONE, M_ERR} mph_t;
  mph_t        ph = M_IDLE;
  int unsigned need, got, quiet;
  logic [31:0] acc;
  logic        e_we;
  logic [13:0] e_addr;
  logic [31:0] e_wdata;
  logic [10:0] e_wl;
  logic [1:0]  e_err;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    e_we = 1'b0;
    if (rst) begin
      ph = M_IDLE; need = 0; got = 0; quiet = 0; acc = 0;
      e_addr = 0; e_wdata = 0; e_wl = 0; e_err = 0; armed = 1'b1;
    end else begin
      case (ph)
        M_IDLE: if (bus.word_valid) begin
          if (bus.word_in[31:16] == 16'hA55A && bus.word_in[10:0] != 11'd0) begin
            need = 32'(bus.word_in[10:0]); got = 0; acc = 0; quiet = 0; e_wl = 0;
            ph = M_LOAD;
          end else begin
            e_err = 2'd1; ph = M_ERR;
          end
        end
        M_LOAD, M_CSUM: begin
          if (bus.word_valid) begin
            quiet = 0;
            if (ph == M_LOAD) begin
              e_we    = 1'b1;
              e_addr  = 14'((32'(BASE) + got) % 16384);
              e_wdata = bus.word_in;
              got++;
              e_wl    = 11'(got);
              acc     = acc + bus.word_in;
              if (got == need) ph = HAS_CK ? M_CSUM : M_DONE;
            end else if (bus.word_in == acc) begin
              ph = M_DONE;
            end else begin
              e_err = 2'd3; ph = M_ERR;
            end
          end else if (quiet == T - 1) begin
            e_err = 2'd2; ph = M_ERR;
          end else begin
            quiet++;
          end
        end
        M_DONE, M_ERR: if (bus.clear) begin
          e_err = 2'd0; ph = M_IDLE;
        end
        default: ph = M_IDLE;
      endcase
    end
  end

  logic [13:0] wa[$];
  logic [31:0] wd[$];

  // Per-cycle compare against the model; also logs every observed write.
  always @(negedge clk) begin
    if (armed) begin
      chk("mem_we", 32'(bus.mem_we), 32'(e_we));
      chk("busy", 32'(bus.busy), 32'(ph == M_LOAD || ph == M_CSUM));
      chk("load_done", 32'(bus.load_done), 32'(ph == M_DONE));
      chk("err_code", 32'(bus.err_code), 32'(e_err));
      chk("words_loaded", 32'(bus.words_loaded), 32'(e_wl));
      if (e_we) begin
        chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        chk("mem_wdata", bus.mem_wdata, e_wdata);
      end
    end
    if (bus.mem_we === 1'b1) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
  end

  task automatic drv(input logic v, input logic [31:0] w, input logic c, input logic r);
    @(posedge clk);
    #1;
    bus.word_valid = v;
    bus.word_in    = w;
    bus.clear      = c;
    rst            = r;
  endtask

  task automatic word(input logic [31:0] w);
    drv(1'b1, w, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, $urandom, 1'b0, 1'b0);
  endtask

  task automatic clr();
    drv(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  int          kind, n, g;
  logic [31:0] hdr, w, s;

  initial begin
    bus.word_valid = 1'b0;
    bus.word_in    = 32'h0;
    bus.clear      = 1'b0;
    repeat (2) drv(1'b0, 32'h0, 1'b0, 1'b1);
    idle(1);
    chk("rst_we", 32'(bus.mem_we), 32'h0);
    chk("rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_err", 32'(bus.err_code), 32'h0);
    chk("rst_wl", 32'(bus.words_loaded), 32'h0);

    // Basic three-word load.
    wa.delete(); wd.delete();
    word(32'hA55A0003); word(32'h11); word(32'h22); word(32'h33);
`ifdef CHECKSUM_EN
    word(32'h66);
    idle(1);
`else
    idle(1);
    chk("done_with_write", 32'({bus.mem_we, bus.load_done}), 32'h3);
    idle(1);
`endif
    chk("load_done", 32'(bus.load_done), 32'h1);
    chk("wl3", 32'(bus.words_loaded), 32'h3);
    chk("err0", 32'(bus.err_code), 32'h0);
    chk("nwrites", wa.size(), 32'd3);
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      chk("log_addr", 32'(wa[i]), 32'(i + 1));
      chk("log_data", wd[i], 32'(32'h11 * (i + 1)));
    end
    clr(); idle(1);
    chk("clear_done", 32'(bus.load_done), 32'h0);
    chk("wl_kept", 32'(bus.words_loaded), 32'h3);

`ifdef CHECKSUM_EN
    wa.delete(); wd.delete();
    word(32'hA55A0003); word(32'h11); word(32'h22); word(32'h33); word(32'h67);
    idle(1);
    chk("sum_err", 32'(bus.err_code), 32'h3);
    chk("sum_nodone", 32'(bus.load_done), 32'h0);
    chk("sum_nwrites", wa.size(), 32'd3);
    clr(); idle(1);
    chk("sum_clr", 32'(bus.err_code), 32'h0);
`else
    word(32'hA55A0001); word(32'h5A);
    idle(1);
    chk("one_we_done", 32'({bus.mem_we, bus.load_done}), 32'h3);
    chk("one_addr", 32'(bus.mem_addr), 32'h1);
    clr();
`endif

    // Bad headers.
    wa.delete(); wd.delete();
    word(32'h12340002); idle(1);
    chk("bad_magic", 32'(bus.err_code), 32'h1);
    clr();
    word(32'hA55A0000); idle(1);
    chk("zero_count", 32'(bus.err_code), 32'h1);
    chk("bad_nowrite", wa.size(), 32'd0);
    clr();

    // Timeout after one of two words.
    word(32'hA55A0002); word(32'h77); idle(20);
    chk("tmo_err", 32'(bus.err_code), 32'h2);
    chk("tmo_nwrites", wa.size(), 32'd1);
    clr();

    // Word on the last allowed cycle keeps the load alive.
    word(32'hA55A0002); word(32'h1); idle(T - 1); word(32'h2);
    idle(1);
    chk("edge_err", 32'(bus.err_code), 32'h0);
    chk("edge_wl", 32'(bus.words_loaded), 32'h2);
`ifdef CHECKSUM_EN
    word(32'h3); idle(1);
`endif
    chk("edge_done", 32'(bus.load_done), 32'h1);
    clr();

    // Reset mid-load.
    word(32'hA55A0003); word(32'hAA); drv(1'b0, 32'h0, 1'b0, 1'b1); idle(1);
    chk("mrst_we", 32'(bus.mem_we), 32'h0);
    chk("mrst_busy", 32'(bus.busy), 32'h0);
    chk("mrst_wl", 32'(bus.words_loaded), 32'h0);
    chk("mrst_addr", 32'(bus.mem_addr), 32'h0);
    word(32'hA55A0003); word(32'hBB); idle(1);
    chk("restart_addr", 32'(bus.mem_addr), 32'h1);
    chk("restart_data", bus.mem_wdata, 32'hBB);
    word(32'hCC); word(32'hDD);
`ifdef CHECKSUM_EN
    word(32'hBB + 32'hCC + 32'hDD);
`endif
    idle(1);
    chk("restart_done", 32'(bus.load_done), 32'h1);
    // clear and word together in DONE: word dropped.
    drv(1'b1, 32'hA55A0001, 1'b1, 1'b0); idle(3);
    chk("clr_wins_busy", 32'(bus.busy), 32'h0);
    chk("clr_wins_done", 32'(bus.load_done), 32'h0);

    // Randomized loads.
    for (int t = 0; t < 250; t++) begin
      kind = $urandom_range(0, 9);
      n    = $urandom_range(1, 6);
      s    = 32'h0;
      if (kind == 0)      hdr = {16'h1234 ^ 16'($urandom), 16'(n)};
      else if (kind == 1) hdr = 32'hA55A0000 | 32'($urandom_range(0, 1) << 12);
      else                hdr = {16'hA55A, 5'($urandom), 11'(n)};
      word(hdr);
      for (int i = 0; i < n; i++) begin
        g = ($urandom_range(0, 19) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 3);
        idle(g);
        if ($urandom_range(0, 39) == 0) drv(1'b0, 32'h0, 1'b0, 1'b1);
        w = $urandom;
        s = s + w;
        word(w);
      end
`ifdef CHECKSUM_EN
      idle($urandom_range(0, 3));
      word(($urandom_range(0, 3) == 0) ? s + 32'h1 : s);
`endif
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) word($urandom);
      if ($urandom_range(0, 3) == 0) drv(1'b1, $urandom, 1'b1, 1'b0);
      else                           clr();
    end
    idle(T + 4);
    clr();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
